uio_bus_arbiter: RTL and testbench

Shares the 8-bit bidirectional `uio` pin bank of the top-level Tiny Tapeout wrapper between up to four internal requesters. Each requester either drives the pins or samples them. The block grants ownership round-robin, limits burst length, and inserts bus-turnaround cycles with all pins released whenever the direction changes. It sits directly between the user logic and `uio_in`/`uio_out`/`uio_oe` in the top module.

---
 rtl/uio_bus_arbiter_pkg.sv | 16 +
 rtl/uio_bus_arbiter_rr_pick.sv | 37 +++
 rtl/uio_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uio_bus_arbiter_pkg.sv
// Shared types and constants for the uio pin-bank arbiter.
package uio_arb_pkg;

  localparam int unsigned UIO_W = 8;   // width of the uio pin bank
  localparam int unsigned IDX_W = 2;   // requester index width (up to 4 requesters)

  localparam logic DIR_IN  = 1'b0;     // requester samples the pins
  localparam logic DIR_OUT = 1'b1;     // requester drives the pins

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping.
module rr_pick
  import uio_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_win,
  output logic             o_any
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // Two passes: indices above i_last first, then wrap to 0..i_last.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_found && i_req[i] && (i > 32'(i_last))) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_found && i_req[i] && (i <= 32'(i_last))) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(i);
      end
    end
  end

  assign o_win = w_idx;
  assign o_any = w_found;

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pin bank with burst cap and
// direction-change turnaround (all pins released during turnaround).
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       dir,
  input  logic [UIO_W*NREQ-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [UIO_W-1:0]      rdata,
  output logic                  rvalid,
  output logic                  busy,
  input  logic [UIO_W-1:0]      uio_in,
  output logic [UIO_W-1:0]      uio_out,
  output logic [UIO_W-1:0]      uio_oe
);

  arb_state_e       r_state;
  logic             r_bus_dir;
  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] r_owner;
  logic [3:0]       r_bcnt;
  logic [1:0]       r_tcnt;
  logic [NREQ-1:0]  r_gnt;
  logic [UIO_W-1:0] r_uio_out;
  logic [UIO_W-1:0] r_uio_oe;
  logic [UIO_W-1:0] r_rdata;
  logic             r_rvalid;
  logic             r_busy;

  logic [IDX_W-1:0] w_win;
  logic             w_any;
  logic [NREQ-1:0]  w_win_oh;
  logic [NREQ-1:0]  w_own_oh;
  logic [UIO_W-1:0] w_win_wdata;
  logic [UIO_W-1:0] w_own_wdata;
  logic             w_win_dir;
  logic             w_own_dir;
  logic             w_own_req;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req  (req),
    .i_last (r_last),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  // Decode winner/owner indices to one-hot and select their data words.
  always_comb begin
    w_win_oh    = '0;
    w_own_oh    = '0;
    w_win_wdata = '0;
    w_own_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_win_oh[i] = (32'(w_win) == i);
      w_own_oh[i] = (32'(r_owner) == i);
      if (w_win_oh[i]) w_win_wdata = wdata[UIO_W*i +: UIO_W];
      if (w_own_oh[i]) w_own_wdata = wdata[UIO_W*i +: UIO_W];
    end
  end

  assign w_win_dir = |(dir & w_win_oh);
  assign w_own_dir = |(dir & w_own_oh);
  assign w_own_req = |(req & w_own_oh);

  // Arbitration FSM with registered grant, pin and read-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bus_dir <= DIR_IN;
      r_last    <= IDX_W'(NREQ - 1);
      r_owner   <= '0;
      r_bcnt    <= '0;
      r_tcnt    <= '0;
      r_gnt     <= '0;
      r_uio_out <= '0;
      r_uio_oe  <= '0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_busy    <= 1'b0;
    end else if (!ena) begin
      r_state   <= IDLE;
      r_bus_dir <= DIR_IN;
      r_gnt     <= '0;
      r_uio_oe  <= '0;
      r_rvalid  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_win;
            r_last  <= w_win;
            r_bcnt  <= '0;
            r_tcnt  <= '0;
            r_busy  <= 1'b1;
            if (w_win_dir == r_bus_dir) begin
              r_state  <= OWN;
              r_gnt    <= w_win_oh;
              r_uio_oe <= {UIO_W{r_bus_dir}};
              if (r_bus_dir == DIR_OUT) r_uio_out <= w_win_wdata;
            end else begin
              r_state  <= TURN;
              r_uio_oe <= '0;
            end
          end
        end
        TURN: begin
          // Abort leaves bus_dir untouched, so pins return to its idle state.
          if (!w_own_req) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_uio_oe <= {UIO_W{r_bus_dir}};
          end else if (r_tcnt == 2'(TURNAROUND - 1)) begin
            r_state   <= OWN;
            r_bus_dir <= w_own_dir;
            r_gnt     <= w_own_oh;
            r_uio_oe  <= {UIO_W{w_own_dir}};
            if (w_own_dir == DIR_OUT) r_uio_out <= w_own_wdata;
          end else begin
            r_tcnt <= r_tcnt + 2'd1;
          end
        end
        OWN: begin
          // Data moves on every OWN edge, including the one that ends the burst.
          if (r_bus_dir == DIR_OUT) begin
            r_uio_out <= w_own_wdata;
          end else begin
            r_rdata  <= uio_in;
            r_rvalid <= 1'b1;
          end
          if (!w_own_req || (r_bcnt == 4'(MAX_BURST - 1))) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_bcnt <= r_bcnt + 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign rdata   = r_rdata;
  assign rvalid  = r_rvalid;
  assign busy    = r_busy;
  assign uio_out = r_uio_out;
  assign uio_oe  = r_uio_oe;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: dut_a (burst 8, turnaround 2) and
// dut_b (burst 4, turnaround 1) share the same stimulus.
module tb_uio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [1:0]  req;
  logic [1:0]  dir;
  logic [15:0] wdata;
  logic [7:0]  uio_in;

  logic [1:0]  gnt_a, gnt_b;
  logic [7:0]  rdata_a, rdata_b, out_a, out_b, oe_a, oe_b;
  logic        rvalid_a, rvalid_b, busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uio_bus_arbiter #(.NREQ(2), .MAX_BURST(8), .TURNAROUND(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .dir(dir), .wdata(wdata),
    .gnt(gnt_a), .rdata(rdata_a), .rvalid(rvalid_a), .busy(busy_a),
    .uio_in(uio_in), .uio_out(out_a), .uio_oe(oe_a)
  );

  uio_bus_arbiter #(.NREQ(2), .MAX_BURST(4), .TURNAROUND(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .dir(dir), .wdata(wdata),
    .gnt(gnt_b), .rdata(rdata_b), .rvalid(rvalid_b), .busy(busy_b),
    .uio_in(uio_in), .uio_out(out_b), .uio_oe(oe_b)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; ena = 1'b1; req = '0; dir = '0; wdata = '0; uio_in = '0;
    step; step;
    rst_n = 1'b1;
    step;
  endtask

  // Output burst by requester 0 so bus_dir ends up as output.
  task automatic prime_out;
    req = 2'b01; dir = 2'b01; wdata[7:0] = 8'h11;
    step; step; step;
    req = 2'b00;
    step; step;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b1; uio_in = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      req = 2'($urandom); dir = 2'($urandom); wdata = 16'($urandom);
      step;
    end
    total++; if (gnt_a !== 2'b00) begin bad++; $display("FAIL rst_gnt: got %b exp %b", gnt_a, 2'b00); end
    total++; if (out_a !== 8'h00) begin bad++; $display("FAIL rst_out: got %h exp %h", out_a, 8'h00); end
    total++; if (oe_a !== 8'h00) begin bad++; $display("FAIL rst_oe: got %h exp %h", oe_a, 8'h00); end
    total++; if (rdata_a !== 8'h00) begin bad++; $display("FAIL rst_rdata: got %h exp %h", rdata_a, 8'h00); end
    total++; if (rvalid_a !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b exp %b", rvalid_a, 1'b0); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b exp %b", busy_a, 1'b0); end
    total++; if (gnt_b !== 2'b00) begin bad++; $display("FAIL rst_gnt_b: got %b exp %b", gnt_b, 2'b00); end
    req = '0; rst_n = 1'b1;
    step; step;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL post_rst_busy: got %b exp %b", busy_a, 1'b0); end
    total++; if (oe_a !== 8'h00) begin bad++; $display("FAIL post_rst_oe: got %h exp %h", oe_a, 8'h00); end
  endtask

  task automatic test_out_burst;
    do_reset;
    prime_out;
    req = 2'b01; dir = 2'b01; wdata[7:0] = 8'hA1;
    step;
    total++; if (gnt_a !== 2'b01) begin bad++; $display("FAIL ob_gnt1: got %b exp %b", gnt_a, 2'b01); end
    total++; if (oe_a !== 8'hFF) begin bad++; $display("FAIL ob_oe1: got %h exp %h", oe_a, 8'hFF); end
    total++; if (out_a !== 8'hA1) begin bad++; $display("FAIL ob_pin1: got %h exp %h", out_a, 8'hA1); end
    wdata[7:0] = 8'hA2;
    step;
    total++; if (gnt_a !== 2'b01) begin bad++; $display("FAIL ob_gnt2: got %b exp %b", gnt_a, 2'b01); end
    total++; if (out_a !== 8'hA2) begin bad++; $display("FAIL ob_pin2: got %h exp %h", out_a, 8'hA2); end
    wdata[7:0] = 8'hA3;
    step;
    total++; if (gnt_a !== 2'b01) begin bad++; $display("FAIL ob_gnt3: got %b exp %b", gnt_a, 2'b01); end
    total++; if (out_a !== 8'hA3) begin bad++; $display("FAIL ob_pin3: got %h exp %h", out_a, 8'hA3); end
    total++; if (oe_a !== 8'hFF) begin bad++; $display("FAIL ob_oe3: got %h exp %h", oe_a, 8'hFF); end
    req = 2'b00;
    step;
    total++; if (gnt_a !== 2'b00) begin bad++; $display("FAIL ob_gnt_end: got %b exp %b", gnt_a, 2'b00); end
    total++; if (oe_a !== 8'hFF) begin bad++; $display("FAIL ob_idle_oe: got %h exp %h", oe_a, 8'hFF); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL ob_idle_busy: got %b exp %b", busy_a, 1'b0); end
    step;
  endtask

  task automatic test_dir_change;
    do_reset;
    prime_out;
    req = 2'b10; dir = 2'b01; uio_in = 8'h5C;
    step;
    total++; if (oe_a !== 8'h00) begin bad++; $display("FAIL dc_oe_t1: got %h exp %h", oe_a, 8'h00); end
    total++; if (gnt_a !== 2'b00) begin bad++; $display("FAIL dc_gnt_t1: got %b exp %b", gnt_a, 2'b00); end
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL dc_busy_t1: got %b exp %b", busy_a, 1'b1); end
    step;
    total++; if (oe_a !== 8'h00) begin bad++; $display("FAIL dc_oe_t2: got %h exp %h", oe_a, 8'h00); end
    total++; if (gnt_a !== 2'b00) begin bad++; $display("FAIL dc_gnt_t2: got %b exp %b", gnt_a, 2'b00); end
    step;
    total++; if (gnt_a !== 2'b10) begin bad++; $display("FAIL dc_gnt_own: got %b exp %b", gnt_a, 2'b10); end
    total++; if (oe_a !== 8'h00) begin bad++; $display("FAIL dc_oe_own: got %h exp %h", oe_a, 8'h00); end
    total++; if (rvalid_a !== 1'b0) begin bad++; $display("FAIL dc_rvalid0: got %b exp %b", rvalid_a, 1'b0); end
    step;
    total++; if (rvalid_a !== 1'b1) begin bad++; $display("FAIL dc_rvalid1: got %b exp %b", rvalid_a, 1'b1); end
    total++; if (rdata_a !== 8'h5C) begin bad++; $display("FAIL dc_rdata1: got %h exp %h", rdata_a, 8'h5C); end
    uio_in = 8'h3E;
    step;
    total++; if (rdata_a !== 8'h3E) begin bad++; $display("FAIL dc_rdata2: got %h exp %h", rdata_a, 8'h3E); end
    uio_in = 8'h77; req = 2'b00;
    step;
    total++; if (gnt_a !== 2'b00) begin bad++; $display("FAIL dc_gnt_end: got %b exp %b", gnt_a, 2'b00); end
    total++; if (rvalid_a !== 1'b1) begin bad++; $display("FAIL dc_rvalid_last: got %b exp %b", rvalid_a, 1'b1); end
    total++; if (rdata_a !== 8'h77) begin bad++; $display("FAIL dc_rdata_last: got %h exp %h", rdata_a, 8'h77); end
    step;
    total++; if (rvalid_a !== 1'b0) begin bad++; $display("FAIL dc_rvalid_off: got %b exp %b", rvalid_a, 1'b0); end
    total++; if (oe_a !== 8'h00) begin bad++; $display("FAIL dc_idle_oe: got %h exp %h", oe_a, 8'h00); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp;
    do_reset;
    dir = 2'b00; req = 2'b11;
    for (int k = 0; k < 19; k++) begin
      step;
      if ((k % 5) == 4)            exp = 2'b00;
      else if (((k / 5) % 2) == 0) exp = 2'b01;
      else                         exp = 2'b10;
      total++; if (gnt_b !== exp) begin bad++; $display("FAIL rr_gnt cycle %0d: got %b exp %b", k, gnt_b, exp); end
    end
    req = 2'b00;
    step; step;
  endtask

  task automatic test_burst_cap;
    logic [29:0] trace;
    logic [29:0] exp;
    int ones;
    do_reset;
    dir = 2'b00; req = 2'b01; ones = 0; trace = '0;
    for (int k = 0; k < 30; k++) begin
      step;
      trace[k] = gnt_a[0];
      if (gnt_a[0]) ones++;
      if (ones == 20) req = 2'b00;
    end
    for (int k = 0; k < 30; k++)
      exp[k] = (k < 8) || (k >= 9 && k < 17) || (k >= 18 && k < 22);
    total++; if (trace !== exp) begin bad++; $display("FAIL bc_trace: got %b exp %b", trace, exp); end
    total++; if (ones != 20) begin bad++; $display("FAIL bc_count: got %0d exp %0d", ones, 20); end
  endtask

  task automatic test_enable_drop;
    do_reset;
    prime_out;
    req = 2'b01; dir = 2'b01; wdata[7:0] = 8'h42;
    step;
    total++; if (gnt_a !== 2'b01) begin bad++; $display("FAIL en_gnt_pre: got %b exp %b", gnt_a, 2'b01); end
    step;
    ena = 1'b0;
    step;
    total++; if (gnt_a !== 2'b00) begin bad++; $display("FAIL en_gnt_off: got %b exp %b", gnt_a, 2'b00); end
    total++; if (oe_a !== 8'h00) begin bad++; $display("FAIL en_oe_off: got %h exp %h", oe_a, 8'h00); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL en_busy_off: got %b exp %b", busy_a, 1'b0); end
    ena = 1'b1;
    step;
    total++; if (gnt_a !== 2'b00) begin bad++; $display("FAIL en_turn1_gnt: got %b exp %b", gnt_a, 2'b00); end
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL en_turn1_busy: got %b exp %b", busy_a, 1'b1); end
    step;
    total++; if (gnt_a !== 2'b00) begin bad++; $display("FAIL en_turn2_gnt: got %b exp %b", gnt_a, 2'b00); end
    total++; if (oe_a !== 8'h00) begin bad++; $display("FAIL en_turn2_oe: got %h exp %h", oe_a, 8'h00); end
    step;
    total++; if (gnt_a !== 2'b01) begin bad++; $display("FAIL en_regnt: got %b exp %b", gnt_a, 2'b01); end
    total++; if (oe_a !== 8'hFF) begin bad++; $display("FAIL en_regnt_oe: got %h exp %h", oe_a, 8'hFF); end
    total++; if (out_a !== 8'h42) begin bad++; $display("FAIL en_regnt_pin: got %h exp %h", out_a, 8'h42); end
    req = 2'b00;
    step; step;
  endtask

  task automatic test_reset_mid_burst;
    do_reset;
    prime_out;
    req = 2'b01; dir = 2'b01; wdata[7:0] = 8'h99;
    step;
    total++; if (out_a !== 8'h99) begin bad++; $display("FAIL arst_pre_pin: got %h exp %h", out_a, 8'h99); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (gnt_a !== 2'b00) begin bad++; $display("FAIL arst_gnt: got %b exp %b", gnt_a, 2'b00); end
    total++; if (oe_a !== 8'h00) begin bad++; $display("FAIL arst_oe: got %h exp %h", oe_a, 8'h00); end
    total++; if (out_a !== 8'h00) begin bad++; $display("FAIL arst_out: got %h exp %h", out_a, 8'h00); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b exp %b", busy_a, 1'b0); end
    total++; if (gnt_b !== 2'b00) begin bad++; $display("FAIL arst_gnt_b: got %b exp %b", gnt_b, 2'b00); end
    req = 2'b00;
    #2 rst_n = 1'b1;
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; req = '0; dir = '0; wdata = '0; uio_in = '0;
    test_reset;
    test_out_burst;
    test_dir_change;
    test_round_robin;
    test_burst_cap;
    test_enable_drop;
    test_reset_mid_burst;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
